// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: 4-way round-robin write arbiter feeding a FIFO.
// Optional burst priority enabled by defining ARB_BURST_EN.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int CNTW      = 5,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] din_bus,
    output logic [3:0]         gnt,
    output logic               fifo_wr_en,
    output logic [WIDTH-1:0]   fifo_din,
    input  logic               fifo_rd_en,
    output logic [CNTW-1:0]    count,
    output logic               full
);

    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      ptr_q;
    logic [1:0]      ptr_d;
    logic [1:0]      win;
    logic [1:0]      idx;
    logic            win_vld;
    logic            space;
    logic            do_wr;
    logic [CNTW-1:0] count_d;

`ifdef ARB_BURST_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);
    logic [BW-1:0] bcnt_q;
    logic [BW-1:0] bcnt_d;
    logic [BW-1:0] run;
`endif

    // Round-robin search starting at ptr; first active request wins.
    always_comb begin
        win_vld = 1'b0;
        win     = ptr_q;
        idx     = ptr_q;
        for (int o = 0; o < 4; o++) begin
            idx = ptr_q + 2'(o);
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win     = idx;
            end
        end
    end

    assign space = (count < DEPTH_C);
    assign do_wr = win_vld && space;

    // Occupancy: a simultaneous write and read leaves count untouched.
    always_comb begin
        count_d = count;
        unique case ({do_wr, fifo_rd_en})
            2'b10:   count_d = count + 1'b1;
            2'b01:   count_d = (count != '0) ? count - 1'b1 : count;
            default: count_d = count;
        endcase
    end

    // Priority pointer update (with optional burst hold on the winner).
`ifdef ARB_BURST_EN
    always_comb begin
        ptr_d  = ptr_q;
        bcnt_d = bcnt_q;
        run    = '0;
        if (do_wr) begin
            run = (win == ptr_q) ? bcnt_q + 1'b1 : BW'(1);
            if (run >= MAXB) begin
                ptr_d  = win + 2'd1;
                bcnt_d = '0;
            end else begin
                ptr_d  = win;
                bcnt_d = run;
            end
        end else if (bcnt_q != '0 && !req[ptr_q]) begin
            ptr_d  = ptr_q + 2'd1;
            bcnt_d = '0;
        end
    end
`else
    always_comb begin
        ptr_d = ptr_q;
        if (do_wr) begin
            ptr_d = win + 2'd1;
        end
    end
`endif

    // Next-state: idle with no requests, stall when full, else grant.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req != 4'b0000 && space) state_d = GRANT;
                else if (req != 4'b0000)     state_d = STALL;
            end
            GRANT: begin
                if (req == 4'b0000) state_d = IDLE;
                else if (!space)    state_d = STALL;
                else                state_d = GRANT;
            end
            STALL: begin
                if (req == 4'b0000) state_d = IDLE;
                else if (space)     state_d = GRANT;
                else                state_d = STALL;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, occupancy and registered FIFO write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            gnt        <= 4'b0000;
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
            count      <= '0;
            full       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt        <= do_wr ? (4'b0001 << win) : 4'b0000;
            fifo_wr_en <= do_wr;
            if (do_wr) begin
                fifo_din <= din_bus[int'(win)*WIDTH +: WIDTH];
            end
            count      <= count_d;
            full       <= (count_d == DEPTH_C);
        end
    end

`ifdef ARB_BURST_EN
    // Burst length counter for the currently favoured requester.
    always_ff @(posedge clk) begin
        if (reset) bcnt_q <= '0;
        else       bcnt_q <= bcnt_d;
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random checks of fifo_wr_arbiter
// against a behavioural model of the arbitration and occupancy rules.
module tb_fifo_wr_arbiter;

    localparam int WIDTH     = 16;
    localparam int DEPTH     = 16;
    localparam int CNTW      = 5;
    localparam int MAX_BURST = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [3:0]         req;
    logic [4*WIDTH-1:0] din_bus;
    logic [3:0]         gnt;
    logic               fifo_wr_en;
    logic [WIDTH-1:0]   fifo_din;
    logic               fifo_rd_en;
    logic [CNTW-1:0]    count;
    logic               full;

    int n_chk  = 0;
    int n_fail = 0;
    int grants = 0;

    // model state
    int         m_ptr;
    int         m_cnt;
    int         m_run;
    logic [3:0] m_gnt;
    logic       m_wr;
    logic [15:0] m_din;

    fifo_wr_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .din_bus(din_bus),
        .gnt(gnt), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .fifo_rd_en(fifo_rd_en), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one clock of the spec's rules to the model.
    task automatic model_edge();
        int win;
        int run;
        if (reset) begin
            m_ptr = 0; m_cnt = 0; m_run = 0;
            m_gnt = 0; m_wr = 0; m_din = 0;
            return;
        end
        win = -1;
        if (m_cnt < DEPTH) begin
            for (int o = 0; o < 4; o++) begin
                if (win < 0 && req[(m_ptr + o) % 4]) win = (m_ptr + o) % 4;
            end
        end
        m_wr  = (win >= 0);
        m_gnt = m_wr ? 4'(1 << win) : 4'b0000;
        if (m_wr) m_din = din_bus[win*WIDTH +: WIDTH];
        if (m_wr && !fifo_rd_en) m_cnt++;
        else if (!m_wr && fifo_rd_en && m_cnt > 0) m_cnt--;
`ifdef ARB_BURST_EN
        if (m_wr) begin
            run = (win == m_ptr) ? m_run + 1 : 1;
            if (run >= MAX_BURST) begin
                m_ptr = (win + 1) % 4; m_run = 0;
            end else begin
                m_ptr = win; m_run = run;
            end
        end else if (m_run != 0 && !req[m_ptr]) begin
            m_ptr = (m_ptr + 1) % 4; m_run = 0;
        end
`else
        run = 0;
        if (m_wr) m_ptr = (win + 1) % 4;
`endif
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, "_gnt"},   32'(gnt),        32'(m_gnt));
        chk({tag, "_wr"},    32'(fifo_wr_en), 32'(m_wr));
        chk({tag, "_din"},   32'(fifo_din),   32'(m_din));
        chk({tag, "_count"}, 32'(count),      32'(m_cnt));
        chk({tag, "_full"},  32'(full),       32'(m_cnt == DEPTH));
        if (gnt != 4'b0000) grants++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step("rst");
        reset = 1'b0;
    endtask

    task automatic set_data();
        for (int i = 0; i < 4; i++) din_bus[i*WIDTH +: WIDTH] = 16'(16'h1000 * (i + 1) + $urandom_range(0, 255));
    endtask

    initial begin
        reset = 1'b1; req = 4'b0000; fifo_rd_en = 1'b0; din_bus = '0;
        m_ptr = 0; m_cnt = 0; m_run = 0; m_gnt = 0; m_wr = 0; m_din = 0;
        step("rst0");
        step("rst1");
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_din", 32'(fifo_din), 32'd0);
        reset = 1'b0;

        // all four requesting, reads every cycle
        req = 4'b1111; fifo_rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_data();
            step("rr4");
        end
        req = 4'b0000; fifo_rd_en = 1'b0;
        step("idle");

        // single requester, known data
        do_reset();
        req = 4'b0100; din_bus[2*WIDTH +: WIDTH] = 16'hA5A5;
        step("one");
        chk("one_data", 32'(fifo_din), 32'h0000A5A5);
        chk("one_gnt",  32'(gnt),      32'h4);
        req = 4'b0000;
        step("one_end");

        // fill to capacity without reads
        do_reset();
        grants = 0;
        req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            set_data();
            step("fill");
        end
        chk("fill_grants", 32'(grants), 32'd16);
        chk("fill_count",  32'(count),  32'd16);
        chk("fill_full",   32'(full),   32'd1);
        chk("fill_state",  32'(dut.state_q), 32'd2);
        fifo_rd_en = 1'b1;
        step("drain1");
        chk("drain_count", 32'(count), 32'd15);
        fifo_rd_en = 1'b0;
        grants = 0;
        for (int i = 0; i < 4; i++) step("refill");
        chk("refill_grants", 32'(grants), 32'd1);
        req = 4'b0000;

        // simultaneous write and read at count 5; read when empty
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 5; i++) step("to5");
        chk("c5", 32'(count), 32'd5);
        fifo_rd_en = 1'b1;
        step("wr_rd");
        chk("c5_hold", 32'(count), 32'd5);
        req = 4'b0000; fifo_rd_en = 1'b0;
        do_reset();
        fifo_rd_en = 1'b1;
        step("rd_empty");
        chk("c0_hold", 32'(count), 32'd0);
        fifo_rd_en = 1'b0;

        // two requesters held: alternating or burst pattern
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            set_data();
            step("pair");
        end
        req = 4'b0000;
        step("pair_end");

        // reset mid-stream at count 7
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 7; i++) step("to7");
        chk("c7", 32'(count), 32'd7);
        reset = 1'b1;
        step("mid_rst");
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_gnt",   32'(gnt),   32'd0);
        reset = 1'b0;
        req = 4'b1010;
        step("post_rst");
        chk("post_rst_gnt", 32'(gnt), 32'h2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            req        = 4'($urandom_range(0, 15));
            fifo_rd_en = ($urandom_range(0, 2) == 0);
            reset      = ($urandom_range(0, 59) == 0);
            set_data();
            step("rand");
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data word width.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning capacity of the downstream FIFO in words.
REQ-003 The block SHALL have parameter CNTW, default 5, meaning occupancy counter width, with DEPTH <= 2^CNTW-1.
REQ-004 The block SHALL have parameter MAX_BURST, default 4, meaning the burst grant limit, used only with ARB_BURST_EN.
REQ-005 Port clk: input, 1 bit, the clock; all logic updates on its rising edge.
REQ-006 Port reset: input, 1 bit, synchronous, active-high reset.
REQ-007 Port req: input, 4 bits, per-requester write request; requester i drives req[i].
REQ-008 Port din_bus: input, 4*WIDTH bits, requester i data on bits [i*WIDTH +: WIDTH].
REQ-009 Port gnt: output, 4 bits, registered one-hot acceptance; gnt[i]=1 means requester i's word was written this cycle.
REQ-010 Port fifo_wr_en: output, 1 bit, registered write strobe to the FIFO.
REQ-011 Port fifo_din: output, WIDTH bits, registered write data to the FIFO.
REQ-012 Port fifo_rd_en: input, 1 bit, downstream read strobe observed for occupancy tracking.
REQ-013 Port count: output, CNTW bits, registered FIFO occupancy.
REQ-014 Port full: output, 1 bit, registered, equal to (count == DEPTH).

Function
REQ-015 Each cycle the block SHALL arbitrate among requesters with req[i]=1 when count < DEPTH, and SHALL issue no grant when count == DEPTH.
REQ-016 Arbitration SHALL be round-robin: search starts at index ptr, ptr..3 then 0..ptr-1, and the first asserted req wins.
REQ-017 Without ARB_BURST_EN, after a grant to requester k, ptr SHALL become (k+1) mod 4; ptr SHALL be unchanged on cycles without a grant.
REQ-018 A win by requester k at edge N SHALL produce gnt=onehot(k), fifo_wr_en=1 and fifo_din=din_bus word k at edge N+1 (one-cycle latency); otherwise gnt=0 and fifo_wr_en=0, with fifo_din holding its last value.
REQ-019 A requester SHALL hold req and data stable until it sees its gnt bit; it may present its next word in the cycle after gnt.
REQ-020 The arbiter SHALL NOT re-grant a requester in the cycle its gnt is high unless req is still asserted; that req is treated as a new word.
REQ-021 count SHALL increment on a write only, decrement on fifo_rd_en with count>0 only, and remain unchanged on a simultaneous write and read, or on fifo_rd_en with count==0.
REQ-022 count SHALL never exceed DEPTH; it SHALL be evaluated including the write issued at the same edge, so at most DEPTH writes occur without reads.
REQ-023 The FSM SHALL have states IDLE (no requests), GRANT (grant issued this cycle) and STALL (requests pending with count==DEPTH).
REQ-024 FSM transitions: IDLE->GRANT on any req with count<DEPTH; GRANT->GRANT while requests remain and space exists; any state->STALL when req!=0 and count==DEPTH; STALL->GRANT the cycle after count drops below DEPTH; any state->IDLE when req==0.

Reset
REQ-025 While reset=1 at an edge: gnt=0, fifo_wr_en=0, fifo_din=0, count=0, full=0, ptr=0, burst counter=0, state=IDLE; reset SHALL override all arbitration, including mid-burst and during STALL.
REQ-026 In the first cycle after reset deasserts, requester 0 SHALL have highest priority.

Configuration
REQ-027 With macro ARB_BURST_EN defined, the winner k SHALL keep priority (ptr=k) for up to MAX_BURST consecutive grants while req[k] stays high; after MAX_BURST grants, or when req[k] drops, ptr SHALL become (k+1) mod 4 and the burst counter SHALL clear.
REQ-028 With ARB_BURST_EN undefined, the burst counter SHALL NOT exist and arbitration SHALL follow REQ-017 exactly.

Verification
REQ-029 Reset, then req=4'b1111 held with fifo_rd_en=1 every cycle -> gnt sequence 0001,0010,0100,1000,0001 with fifo_wr_en=1 each cycle; count stays 0 after the first write.
REQ-030 req=4'b0100 only, with data 16'hA5A5 -> the next cycle shows gnt=0100, fifo_wr_en=1 and fifo_din=16'hA5A5.
REQ-031 No reads, req[0] held for 20 cycles -> exactly 16 grants, count=16, full=1, state STALL; then one fifo_rd_en pulse -> count=15, and exactly one more grant follows.
REQ-032 count=5 with a simultaneous grant and fifo_rd_en -> count stays 5; fifo_rd_en at count=0 -> count stays 0.
REQ-033 ARB_BURST_EN with MAX_BURST=4 and req=4'b0011 held -> gnt pattern 0001 x4, 0010 x4, 0001 x4; without the macro -> 0001,0010 alternating.
REQ-034 reset asserted mid-burst with count=7 -> the next cycle shows count=0, gnt=0 and fifo_wr_en=0, and the first grant after release goes to the lowest-index active requester.
